// File: rtl/mul_pkg.sv
// Shared arithmetic-block definitions: FSM state encoding and counter sizing.
package mul_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to hold values 0 .. v-1 (at least 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_shift_add_mul_if.sv
// Operand/result valid-ready bundle for the sequential multiplier.
interface seq_shift_add_mul_if #(
  parameter int unsigned WIDTH = 8
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, p
  );

endinterface

// File: rtl/twos_abs.sv
// Conditional two's-complement magnitude: strips the sign when en_i is set.
module twos_abs #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] mag_c,
  output logic             sign_c
);

  // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
  assign sign_c = en_i & x_i[WIDTH-1];
  assign mag_c  = sign_c ? WIDTH'(-x_i) : x_i;

endmodule

// File: rtl/seq_shift_add_mul.sv
// Sequential shift-and-add multiplier, WIDTH steps per product, signed or unsigned
// per transaction, with valid/ready on both operand and result sides.
module seq_shift_add_mul
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_shift_add_mul_if.slave bus
);

  localparam int unsigned CW = clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    p_q, p_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic             a_sign_c, b_sign_c;
  logic [WIDTH:0]   sum_c;
  logic [PW-1:0]    prod_c;

  twos_abs #(.WIDTH(WIDTH)) u_abs_a (
    .x_i    (bus.a),
    .en_i   (bus.signed_mode),
    .mag_c  (a_mag_c),
    .sign_c (a_sign_c)
  );

  twos_abs #(.WIDTH(WIDTH)) u_abs_b (
    .x_i    (bus.b),
    .en_i   (bus.signed_mode),
    .mag_c  (b_mag_c),
    .sign_c (b_sign_c)
  );

  // Next state: one add/shift per BUSY cycle; multiplier bits retire as product bits enter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    p_d     = p_q;

    sum_c  = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_c = {sum_c, mplr_q[WIDTH-1:1]};

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_BUSY;
          mcand_d = a_mag_c;
          mplr_d  = b_mag_c;
          neg_d   = a_sign_c ^ b_sign_c;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
        end
      end
      ST_BUSY: begin
        acc_d  = prod_c[PW-1:WIDTH];
        mplr_d = prod_c[WIDTH-1:0];
        if (cnt_q == '0) begin
          p_d     = neg_q ? PW'(-prod_c) : prod_c;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mplr_q      <= '0;
      mcand_q     <= '0;
      neg_q       <= 1'b0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mplr_q      <= mplr_d;
      mcand_q     <= mcand_d;
      neg_q       <= neg_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Scoreboard bench for seq_shift_add_mul at WIDTH=4 and WIDTH=8.
module tb_seq_shift_add_mul;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0]  q4[$];
  logic [15:0] q8[$];

  seq_shift_add_mul_if #(.WIDTH(4)) if4 ();
  seq_shift_add_mul_if #(.WIDTH(8)) if8 ();

  seq_shift_add_mul #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  seq_shift_add_mul #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
    logic [7:0] ea;
    logic [7:0] eb;
    ea = s ? {{4{a[3]}}, a} : {4'b0, a};
    eb = s ? {{4{b[3]}}, b} : {4'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] ea;
    logic [15:0] eb;
    ea = s ? {{8{a[7]}}, a} : {8'b0, a};
    eb = s ? {{8{b[7]}}, b} : {8'b0, b};
    return ea * eb;
  endfunction

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s, input string name);
    int lat;
    logic [7:0] exp;
    if4.a = a; if4.b = b; if4.signed_mode = s;
    if4.in_valid = 1'b1; if4.out_ready = 1'b1;
    lat = 0;
    while (!if4.in_ready && lat < 50) begin tick(); lat++; end
    q4.push_back(ref4(a, b, s));
    tick();
    if4.in_valid = 1'b0;
    lat = 0;
    while (!if4.out_valid && lat < 50) begin tick(); lat++; end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL %s latency got %0d want 4", name, lat);
    end
    exp = q4.pop_front();
    checks++;
    if (if4.p !== exp) begin
      errors++;
      $display("FAIL %s p got %h want %h", name, if4.p, exp);
    end
    tick();
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, input string name);
    int lat;
    logic [15:0] exp;
    if8.a = a; if8.b = b; if8.signed_mode = s;
    if8.in_valid = 1'b1; if8.out_ready = 1'b1;
    lat = 0;
    while (!if8.in_ready && lat < 50) begin tick(); lat++; end
    q8.push_back(ref8(a, b, s));
    tick();
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 50) begin tick(); lat++; end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL %s latency got %0d want 8 (a=%0d b=%0d s=%0d)", name, lat, a, b, s);
    end
    exp = q8.pop_front();
    checks++;
    if (if8.p !== exp) begin
      errors++;
      $display("FAIL %s p got %h want %h (a=%0d b=%0d s=%0d)", name, if8.p, exp, a, b, s);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks += 6;
    if (if4.in_ready !== 1'b1)  begin errors++; $display("FAIL reset in_ready4 got %b want 1", if4.in_ready); end
    if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid4 got %b want 0", if4.out_valid); end
    if (if4.p !== 8'h00)        begin errors++; $display("FAIL reset p4 got %h want 00", if4.p); end
    if (if8.in_ready !== 1'b1)  begin errors++; $display("FAIL reset in_ready8 got %b want 1", if8.in_ready); end
    if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid8 got %b want 0", if8.out_valid); end
    if (if8.p !== 16'h0000)     begin errors++; $display("FAIL reset p8 got %h want 0000", if8.p); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned4();
    run4(4'd11, 4'd5, 1'b0, "u4_11x5");
    run4(4'd15, 4'd15, 1'b0, "u4_15x15");
  endtask

  task automatic test_signed4();
    run4(4'b1101, 4'd5, 1'b1, "s4_m3x5");
    run4(4'b1000, 4'b1000, 1'b1, "s4_m8xm8");
    run4(4'b1000, 4'd7, 1'b1, "s4_m8x7");
  endtask

  task automatic test_backpressure8();
    int k;
    logic [15:0] exp;
    if8.a = 8'd200; if8.b = 8'd3; if8.signed_mode = 1'b0;
    if8.in_valid = 1'b1; if8.out_ready = 1'b0;
    q8.push_back(ref8(8'd200, 8'd3, 1'b0));
    tick();
    if8.in_valid = 1'b0;
    k = 0;
    while (!if8.out_valid && k < 50) begin
      checks++;
      if (if8.in_ready !== 1'b0) begin errors++; $display("FAIL bp busy_in_ready got %b want 0", if8.in_ready); end
      if (k == 2) begin
        if8.a = 8'd1; if8.b = 8'd1; if8.in_valid = 1'b1;
      end else begin
        if8.in_valid = 1'b0;
      end
      tick();
      k++;
    end
    if8.in_valid = 1'b0;
    checks++;
    if (k !== 8) begin errors++; $display("FAIL bp latency got %0d want 8", k); end
    exp = q8.pop_front();
    for (int i = 0; i < 6; i++) begin
      checks += 3;
      if (if8.out_valid !== 1'b1) begin errors++; $display("FAIL bp hold_valid got %b want 1", if8.out_valid); end
      if (if8.in_ready !== 1'b0)  begin errors++; $display("FAIL bp hold_in_ready got %b want 0", if8.in_ready); end
      if (if8.p !== exp)          begin errors++; $display("FAIL bp hold_p got %h want %h", if8.p, exp); end
      tick();
    end
    if8.out_ready = 1'b1;
    checks++;
    if (if8.p !== exp) begin errors++; $display("FAIL bp final_p got %h want %h", if8.p, exp); end
    tick();
    if8.out_ready = 1'b0;
    checks += 2;
    if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL bp released_valid got %b want 0", if8.out_valid); end
    if (if8.in_ready !== 1'b1)  begin errors++; $display("FAIL bp released_ready got %b want 1", if8.in_ready); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL bp ignored_pulse got out_valid %b want 0", if8.out_valid); end
      tick();
    end
  endtask

  task automatic test_back_to_back8();
    logic [7:0]  av [3];
    logic [7:0]  bv [3];
    logic [15:0] exp;
    logic        acc_now;
    logic        cons_now;
    int sent, got, last_acc, cyc;
    av[0] = 8'd17;  bv[0] = 8'd200;
    av[1] = 8'd250; bv[1] = 8'd250;
    av[2] = 8'd99;  bv[2] = 8'd3;
    sent = 0; got = 0; last_acc = -1; cyc = 0;
    if8.signed_mode = 1'b0; if8.a = av[0]; if8.b = bv[0];
    if8.in_valid = 1'b1; if8.out_ready = 1'b1;
    while (got < 3 && cyc < 200) begin
      acc_now  = if8.in_valid && if8.in_ready;
      cons_now = if8.out_valid && if8.out_ready;
      if (cons_now) begin
        checks++;
        if (q8.size() == 0) begin
          errors++; $display("FAIL b2b unexpected result p %h", if8.p);
        end else begin
          exp = q8.pop_front();
          if (if8.p !== exp) begin errors++; $display("FAIL b2b p%0d got %h want %h", got, if8.p, exp); end
        end
        got++;
      end
      if (acc_now) begin
        q8.push_back(ref8(if8.a, if8.b, 1'b0));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== 10) begin errors++; $display("FAIL b2b spacing got %0d want 10", cyc - last_acc); end
        end
        last_acc = cyc;
        sent++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        if (sent < 3) begin if8.a = av[sent]; if8.b = bv[sent]; end
        else if8.in_valid = 1'b0;
      end
    end
    if8.in_valid = 1'b0;
    checks++;
    if (got !== 3) begin errors++; $display("FAIL b2b timeout got %0d results want 3", got); end
  endtask

  task automatic test_reset_mid4();
    if4.a = 4'd7; if4.b = 4'd7; if4.signed_mode = 1'b0;
    if4.in_valid = 1'b1; if4.out_ready = 1'b1;
    tick();
    if4.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 3;
    if (if4.in_ready !== 1'b1)  begin errors++; $display("FAIL midrst in_ready got %b want 1", if4.in_ready); end
    if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL midrst out_valid got %b want 0", if4.out_valid); end
    if (if4.p !== 8'h00)        begin errors++; $display("FAIL midrst p got %h want 00", if4.p); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL midrst discarded got out_valid %b want 0", if4.out_valid); end
      tick();
    end
    run4(4'd9, 4'd3, 1'b0, "midrst_9x3");
  endtask

  task automatic test_random8();
    logic [7:0] ca [8];
    logic [7:0] cb [8];
    logic       cs [8];
    ca[0] = 8'd0;   cb[0] = 8'd0;   cs[0] = 1'b0;
    ca[1] = 8'd0;   cb[1] = 8'd255; cs[1] = 1'b1;
    ca[2] = 8'd128; cb[2] = 8'd128; cs[2] = 1'b1;
    ca[3] = 8'd128; cb[3] = 8'd127; cs[3] = 1'b1;
    ca[4] = 8'd255; cb[4] = 8'd255; cs[4] = 1'b0;
    ca[5] = 8'd255; cb[5] = 8'd255; cs[5] = 1'b1;
    ca[6] = 8'd128; cb[6] = 8'd255; cs[6] = 1'b1;
    ca[7] = 8'd128; cb[7] = 8'd128; cs[7] = 1'b0;
    for (int i = 0; i < 8; i++) run8(ca[i], cb[i], cs[i], "corner8");
    for (int i = 0; i < 992; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), "rand8");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.signed_mode = 1'b0; if4.out_ready = 1'b0;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.signed_mode = 1'b0; if8.out_ready = 1'b0;
    test_reset();
    test_unsigned4();
    test_signed4();
    test_backpressure8();
    test_back_to_back8();
    test_reset_mid4();
    test_random8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
